// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the 5-stage MIPS core: opcode constants, ALU op
// classes and the 10-bit decoded control word in the exact bit order that
// control_unit emits (regdst in the MSB down to aluop in the two LSBs).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // A bubble is an all-zero control word: no register or memory write.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_if
// Bundle between the ID stage and the ID/EX pipeline register.
//   master : ID-stage side, drives id_* fields plus stall/flush and
//            observes the EX copies, ex_valid and the hazard controls.
//   slave  : the pipeline register itself.
// Optional macro ID_EX_PERF_CNT_EN adds the bubble_cnt/stall_cnt counters.
interface id_ex_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               id_regdst, id_alusrc, id_memtoreg, id_regwrite;
    logic               id_memread, id_memwrite, id_branch, id_jump;
    logic [1:0]         id_aluop;
    logic [DATA_W-1:0]  id_pc4, id_rd1, id_rd2, id_imm;
    logic [RADDR_W-1:0] id_rs, id_rt, id_rd;
    logic [5:0]         id_funct;
    logic               stall, flush;

    logic               ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
    logic               ex_memread, ex_memwrite, ex_branch, ex_jump;
    logic [1:0]         ex_aluop;
    logic [DATA_W-1:0]  ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [RADDR_W-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0]         ex_funct;
    logic               ex_valid, load_use, pc_write, ifid_write;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]        bubble_cnt, stall_cnt;
`endif

    modport master (
`ifdef ID_EX_PERF_CNT_EN
        input  bubble_cnt, stall_cnt,
`endif
        output id_regdst, id_alusrc, id_memtoreg, id_regwrite,
               id_memread, id_memwrite, id_branch, id_jump, id_aluop,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               stall, flush,
        input  ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
               ex_memread, ex_memwrite, ex_branch, ex_jump, ex_aluop,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               ex_valid, load_use, pc_write, ifid_write
    );

    modport slave (
`ifdef ID_EX_PERF_CNT_EN
        output bubble_cnt, stall_cnt,
`endif
        input  id_regdst, id_alusrc, id_memtoreg, id_regwrite,
               id_memread, id_memwrite, id_branch, id_jump, id_aluop,
               id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               stall, flush,
        output ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
               ex_memread, ex_memwrite, ex_branch, ex_jump, ex_aluop,
               ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               ex_valid, load_use, pc_write, ifid_write
    );

endinterface

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// hazard_detect
// Purely combinational load-use detector, kept standalone so the forwarding
// unit's bench can reuse it.
//   ex_valid_i, ex_memread_i, ex_rt_i : state of the instruction in EX
//   id_rs_i, id_rt_i                  : source registers of the ID instruction
//   stall_i                           : external freeze
//   load_use_o                        : ID needs a value a load has not produced yet
//   pc_write_o, ifid_write_o          : front-end update enables
module hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               ex_valid_i,
    input  logic               ex_memread_i,
    input  logic [RADDR_W-1:0] ex_rt_i,
    input  logic [RADDR_W-1:0] id_rs_i,
    input  logic [RADDR_W-1:0] id_rt_i,
    input  logic               stall_i,
    output logic               load_use_o,
    output logic               pc_write_o,
    output logic               ifid_write_o
);

    // A load into $zero never produces a real dependency, so it is excluded.
    assign load_use_o = ex_valid_i & ex_memread_i & (ex_rt_i != '0)
                      & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

    assign pc_write_o   = ~load_use_o & ~stall_i;
    assign ifid_write_o = ~load_use_o & ~stall_i;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
// ID/EX pipeline register with integrated load-use bubble insertion.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : id_ex_if.slave carrying id_* inputs, stall/flush, ex_* copies,
//           ex_valid, load_use, pc_write, ifid_write
// Edge priority: flush (bubble) > stall (hold) > load_use (bubble) > capture.
// Optional macro ID_EX_PERF_CNT_EN adds bubble_cnt and stall_cnt.
module id_ex_pipe_reg
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);

    ctrl_t              ctrl_q, ctrl_d, idCtrl;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [RADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]         funct_q, funct_d;
    logic               loadUse;

    assign idCtrl = {bus.id_regdst, bus.id_alusrc, bus.id_memtoreg, bus.id_regwrite,
                     bus.id_memread, bus.id_memwrite, bus.id_branch, bus.id_jump,
                     bus.id_aluop};

    hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_rt_i      (rt_q),
        .id_rs_i      (bus.id_rs),
        .id_rt_i      (bus.id_rt),
        .stall_i      (bus.stall),
        .load_use_o   (loadUse),
        .pc_write_o   (bus.pc_write),
        .ifid_write_o (bus.ifid_write)
    );

    // Next-state selection. Data fields follow the inputs whenever the
    // register is not frozen; only the control word and valid distinguish
    // a bubble from a real capture.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        if (bus.flush || !bus.stall) begin
            pc4_d   = bus.id_pc4;
            rd1_d   = bus.id_rd1;
            rd2_d   = bus.id_rd2;
            imm_d   = bus.id_imm;
            rs_d    = bus.id_rs;
            rt_d    = bus.id_rt;
            rd_d    = bus.id_rd;
            funct_d = bus.id_funct;
        end
        if (bus.flush) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (loadUse) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end else begin
            ctrl_d  = idCtrl;
            valid_d = 1'b1;
        end
    end

    // Pipeline state register; reset empties the EX slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
        end
    end

    assign bus.ex_regdst   = ctrl_q.regdst;
    assign bus.ex_alusrc   = ctrl_q.alusrc;
    assign bus.ex_memtoreg = ctrl_q.memtoreg;
    assign bus.ex_regwrite = ctrl_q.regwrite;
    assign bus.ex_memread  = ctrl_q.memread;
    assign bus.ex_memwrite = ctrl_q.memwrite;
    assign bus.ex_branch   = ctrl_q.branch;
    assign bus.ex_jump     = ctrl_q.jump;
    assign bus.ex_aluop    = ctrl_q.aluop;
    assign bus.ex_pc4      = pc4_q;
    assign bus.ex_rd1      = rd1_q;
    assign bus.ex_rd2      = rd2_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs       = rs_q;
    assign bus.ex_rt       = rt_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_funct    = funct_q;
    assign bus.ex_valid    = valid_q;
    assign bus.load_use    = loadUse;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubbleCnt_q, bubbleCnt_d, stallCnt_q, stallCnt_d;

    // A load-use bubble is only counted when it actually enters EX, i.e.
    // neither a flush nor a stall overrides it on this edge.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        stallCnt_d  = stallCnt_q;
        if (!bus.flush && !bus.stall && loadUse) begin
            bubbleCnt_d = bubbleCnt_q + 32'd1;
        end
        if (bus.stall) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    // Counter registers, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbleCnt_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            bubbleCnt_q <= bubbleCnt_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign bus.bubble_cnt = bubbleCnt_q;
    assign bus.stall_cnt  = stallCnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg
// Table-driven bench for id_ex_pipe_reg with a scoreboard queue of expected
// EX-slot contents, plus hand-written reset and counter sequences.
module tb_id_ex_pipe_reg;

    localparam logic [9:0] C_ADD = 10'b1001000010;
    localparam logic [9:0] C_LW  = 10'b0111100000;
    localparam logic [9:0] C_SW  = 10'b0100010000;
    localparam logic [9:0] C_BEQ = 10'b0000001001;
    localparam int NV = 18;

    typedef struct {
        logic [9:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [5:0]  funct;
        logic        stall, flush;
        logic        expLu;
        logic [9:0]  expCtrl;
        logic        expValid;
        int          expSrc;
    } vec_t;

    typedef struct {
        logic [9:0] ctrl;
        logic       valid;
        int         src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   expBubble = 0;
    int   expStall = 0;
    vec_t vecs [NV];
    exp_t sbq [$];

    id_ex_if #(.DATA_W(32), .RADDR_W(5)) bus ();

    id_ex_pipe_reg #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(logic [9:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rd1, logic st, logic fl, logic lu,
                                logic [9:0] ec, logic ev, int src);
        vec_t v;
        v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.rd1 = rd1;
        v.stall = st; v.flush = fl; v.expLu = lu;
        v.expCtrl = ec; v.expValid = ev; v.expSrc = src;
        v.pc4 = 32'h0; v.rd2 = 32'h0; v.imm = 32'h0; v.funct = 6'h0;
        return v;
    endfunction

    function automatic logic [9:0] exCtrl();
        return {bus.ex_regdst, bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite,
                bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_jump, bus.ex_aluop};
    endfunction

    function automatic logic [148:0] exData();
        return {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_pc4, bus.ex_rd1,
                bus.ex_rd2, bus.ex_imm, bus.ex_funct};
    endfunction

    function automatic logic [148:0] vecData(vec_t v);
        return {v.rs, v.rt, v.rd, v.pc4, v.rd1, v.rd2, v.imm, v.funct};
    endfunction

    task automatic checkOutput(string name, logic [148:0] act, logic [148:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic driveId(vec_t v);
        {bus.id_regdst, bus.id_alusrc, bus.id_memtoreg, bus.id_regwrite,
         bus.id_memread, bus.id_memwrite, bus.id_branch, bus.id_jump, bus.id_aluop} = v.ctrl;
        bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_rd = v.rd;
        bus.id_pc4 = v.pc4; bus.id_rd1 = v.rd1; bus.id_rd2 = v.rd2;
        bus.id_imm = v.imm; bus.id_funct = v.funct;
        bus.stall = v.stall; bus.flush = v.flush;
    endtask

    // Drive one vector after the falling edge, check the combinational
    // hazard outputs, then compare the EX slot popped from the scoreboard.
    task automatic applyStimulus(int i);
        exp_t e;
        exp_t got;
        logic expPcw;
        @(negedge clk);
        driveId(vecs[i]);
        #1;
        expPcw = ~vecs[i].expLu & ~vecs[i].stall;
        checkOutput($sformatf("load_use[%0d]", i), 149'(bus.load_use), 149'(vecs[i].expLu));
        checkOutput($sformatf("pc_write[%0d]", i), 149'(bus.pc_write), 149'(expPcw));
        checkOutput($sformatf("ifid_write[%0d]", i), 149'(bus.ifid_write), 149'(expPcw));
        e.ctrl = vecs[i].expCtrl; e.valid = vecs[i].expValid; e.src = vecs[i].expSrc;
        sbq.push_back(e);
        expBubble += (vecs[i].expLu && !vecs[i].flush && !vecs[i].stall) ? 1 : 0;
        expStall  += vecs[i].stall ? 1 : 0;
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        checkOutput($sformatf("ex_ctrl[%0d]", i), 149'(exCtrl()), 149'(got.ctrl));
        checkOutput($sformatf("ex_valid[%0d]", i), 149'(bus.ex_valid), 149'(got.valid));
        if (got.src >= 0)
            checkOutput($sformatf("ex_data[%0d]", i), exData(), vecData(vecs[got.src]));
    endtask

    initial begin
        vec_t lw;
        vec_t add;
        vecs[0]  = mk(C_ADD,  8,  9, 10, 32'h5,   0, 0, 0, C_ADD, 1, 0);
        vecs[1]  = mk(C_LW,  29,  9,  0, 32'h100, 0, 0, 0, C_LW,  1, 1);
        vecs[2]  = mk(C_ADD,  9,  8, 10, 32'h11,  0, 0, 1, 10'h0, 0, -1);
        vecs[3]  = mk(C_ADD,  9,  8, 10, 32'h11,  0, 0, 0, C_ADD, 1, 3);
        vecs[4]  = mk(C_LW,   8,  0,  0, 32'h200, 0, 0, 0, C_LW,  1, 4);
        vecs[5]  = mk(C_ADD,  0,  0, 10, 32'h22,  0, 0, 0, C_ADD, 1, 5);
        vecs[6]  = mk(C_SW,   8,  9,  0, 32'h33,  1, 1, 0, 10'h0, 0, -1);
        vecs[7]  = mk(C_BEQ,  8,  9,  0, 32'h44,  0, 0, 0, C_BEQ, 1, 7);
        vecs[8]  = mk(C_ADD,  8,  9, 10, 32'h55,  1, 0, 0, C_BEQ, 1, 7);
        vecs[9]  = mk(C_ADD,  8,  9, 10, 32'h56,  1, 0, 0, C_BEQ, 1, 7);
        vecs[10] = mk(C_ADD,  8,  9, 10, 32'h57,  1, 0, 0, C_BEQ, 1, 7);
        vecs[11] = mk(C_LW,  29,  9,  0, 32'h66,  0, 0, 0, C_LW,  1, 11);
        vecs[12] = mk(C_ADD,  8,  9, 10, 32'h77,  1, 0, 1, C_LW,  1, 11);
        vecs[13] = mk(C_ADD,  8,  9, 10, 32'h77,  0, 0, 1, 10'h0, 0, -1);
        vecs[14] = mk(C_ADD,  8,  9, 10, 32'h77,  0, 0, 0, C_ADD, 1, 14);
        vecs[15] = mk(C_LW,  29,  9,  0, 32'h88,  0, 0, 0, C_LW,  1, 15);
        vecs[16] = mk(C_ADD,  9,  8, 10, 32'h99,  0, 1, 1, 10'h0, 0, -1);
        vecs[17] = mk(C_BEQ,  1,  2,  0, 32'hAA,  0, 0, 0, C_BEQ, 1, 17);
        for (int i = 0; i < NV; i++) begin
            vecs[i].pc4   = 32'h400 + 32'(4 * i);
            vecs[i].rd2   = 32'h1000 + 32'(i);
            vecs[i].imm   = 32'hFFFF0000 | 32'(i);
            vecs[i].funct = 6'(32 + i);
        end
        vecs[0].rd2 = 32'h7;

        driveId(mk(10'h0, 0, 0, 0, 0, 0, 0, 0, 10'h0, 0, -1));
        #12;
        checkOutput("reset_ctrl", 149'(exCtrl()), 149'(0));
        checkOutput("reset_valid", 149'(bus.ex_valid), 149'(0));
        checkOutput("reset_data", exData(), 149'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) applyStimulus(i);

`ifdef ID_EX_PERF_CNT_EN
        checkOutput("bubble_cnt", 149'(bus.bubble_cnt), 149'(expBubble));
        checkOutput("stall_cnt", 149'(bus.stall_cnt), 149'(expStall));
`endif

        // Reset mid-run with a lw in ID: EX slot must clear before any edge.
        lw = mk(C_LW, 29, 9, 0, 32'h123, 0, 0, 0, 10'h0, 0, -1);
        @(negedge clk);
        driveId(lw);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_ctrl", 149'(exCtrl()), 149'(0));
        checkOutput("midreset_valid", 149'(bus.ex_valid), 149'(0));
        checkOutput("midreset_data", exData(), 149'(0));
        checkOutput("midreset_pc_write", 149'(bus.pc_write), 149'(1));
`ifdef ID_EX_PERF_CNT_EN
        checkOutput("midreset_bubble_cnt", 149'(bus.bubble_cnt), 149'(0));
        checkOutput("midreset_stall_cnt", 149'(bus.stall_cnt), 149'(0));
`endif
        @(posedge clk);
        #1;
        checkOutput("held_reset_valid", 149'(bus.ex_valid), 149'(0));
        @(negedge clk);
        rst_n = 1'b1;
        add = mk(C_ADD, 8, 9, 10, 32'h321, 0, 0, 0, 10'h0, 0, -1);
        driveId(add);
        @(posedge clk);
        #1;
        checkOutput("post_reset_ctrl", 149'(exCtrl()), 149'(C_ADD));
        checkOutput("post_reset_valid", 149'(bus.ex_valid), 149'(1));
        checkOutput("post_reset_data", exData(), vecData(add));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
